// File: rtl/pc_unit_if.sv
// pc_unit_if: control-unit <-> program-counter bundle.
//   master (control unit): drives en, op, is_zero, target, clr_err;
//                          observes pc and the return-address-stack status.
//   slave  (pc_unit)     : the reverse.
//   en        update enable (PCWrite)
//   op        next-PC mode: 0 NEXT,1 BEQ,2 BNE,3 JUMP,4 CALL,5 RET,6/7 HOLD
//   is_zero   ALU zero flag, sampled with op
//   target    absolute branch/jump/call destination
//   clr_err   clears the sticky stack error flags
//   pc        current (registered) program counter
//   ras_count valid return-stack entries; ras_empty/ras_full decoded from it
//   ras_ovf   sticky: CALL while full; ras_unf sticky: RET while empty
interface pc_unit_if #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic             en;
  logic [2:0]       op;
  logic             is_zero;
  logic [WIDTH-1:0] target;
  logic             clr_err;
  logic [WIDTH-1:0] pc;
  logic [CW-1:0]    ras_count;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output en, op, is_zero, target, clr_err,
    input  pc, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  en, op, is_zero, target, clr_err,
    output pc, ras_count, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with sequential / conditional-branch / jump /
// call / return / hold modes, an internal return-address stack and sticky
// stack-error flags. One PC update per enabled cycle, pc is registered.
//   clock  system clock, rising edge
//   reset  asynchronous, active-high; pc=RESET_VEC, stack empty, flags clear
//   bus    pc_unit_if.slave (see interface header for signal list)
module pc_unit #(
  parameter int               WIDTH     = 16,
  parameter int unsigned      INC       = 1,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input logic       clock,
  input logic       reset,
  pc_unit_if.slave  bus
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_BEQ  = 3'd1,
    OP_BNE  = 3'd2,
    OP_JUMP = 3'd3,
    OP_CALL = 3'd4,
    OP_RET  = 3'd5,
    OP_HOLD = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  logic [WIDTH-1:0] pc_q, pc_nxt, seq;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             ovf_q, unf_q;
  logic             full, empty;
  logic             push, ovf_set, unf_set;
  logic [AW-1:0]    push_idx, top_idx;
  logic [WIDTH-1:0] ras [RAS_DEPTH];
  op_e              op;

  assign op    = op_e'(bus.op);
  assign seq   = pc_q + WIDTH'(INC);
  assign full  = (cnt_q == CW'(RAS_DEPTH));
  assign empty = (cnt_q == '0);

  // count never exceeds RAS_DEPTH <= 2**AW, so the low AW bits suffice to
  // address the stack, and (count-1) mod 2**AW is the top entry
  assign push_idx = cnt_q[AW-1:0];
  assign top_idx  = push_idx - AW'(1);

  always_comb begin
    pc_nxt  = pc_q;
    cnt_nxt = cnt_q;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (bus.en) begin
      unique case (op)
        OP_NEXT: pc_nxt = seq;
        OP_BEQ:  pc_nxt = bus.is_zero ? bus.target : seq;
        OP_BNE:  pc_nxt = bus.is_zero ? seq : bus.target;
        OP_JUMP: pc_nxt = bus.target;
        OP_CALL: begin
          pc_nxt = bus.target;
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            push    = 1'b1;
            cnt_nxt = cnt_q + CW'(1);
          end
        end
        OP_RET: begin
          if (empty) begin
            unf_set = 1'b1;
          end else begin
            pc_nxt  = ras[top_idx];
            cnt_nxt = cnt_q - CW'(1);
          end
        end
        OP_HOLD, OP_RSVD: ;
        default: ;
      endcase
    end
  end

  // control state: pc, stack depth and sticky flags
  // a same-edge error event beats clr_err; clr_err works even with en=0
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_nxt;
      cnt_q <= cnt_nxt;
      ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
      unf_q <= unf_set | (unf_q & ~bus.clr_err);
    end
  end

  // stack storage: data only, contents are don't-care after reset
  always_ff @(posedge clock) begin
    if (push) ras[push_idx] <= seq;
  end

  assign bus.pc        = pc_q;
  assign bus.ras_count = cnt_q;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = full;
  assign bus.ras_ovf   = ovf_q;
  assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  localparam int W = 16;
  localparam int D = 4;

  typedef struct packed {
    logic [W-1:0] pc;
    logic [2:0]   cnt;
    logic         full;
    logic         empty;
    logic         ovf;
    logic         unf;
  } obs_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  pc_unit_if #(.WIDTH(W), .RAS_DEPTH(D)) bus ();

  pc_unit #(.WIDTH(W), .INC(1), .RAS_DEPTH(D), .RESET_VEC('0)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  obs_t exp_q[$];
  obs_t act_q[$];

  // reference model
  logic [W-1:0] m_pc;
  logic [W-1:0] m_ras[$];
  logic         m_ovf, m_unf;

  function automatic obs_t model_obs();
    obs_t o;
    o.pc    = m_pc;
    o.cnt   = 3'(m_ras.size());
    o.full  = (m_ras.size() == D);
    o.empty = (m_ras.size() == 0);
    o.ovf   = m_ovf;
    o.unf   = m_unf;
    return o;
  endfunction

  task automatic model_reset();
    m_pc = '0;
    m_ras.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic [2:0] op,
                            input logic z, input logic [W-1:0] tgt,
                            input logic clr);
    logic [W-1:0] s;
    logic set_o, set_u;
    s = m_pc + 16'd1;
    set_o = 1'b0;
    set_u = 1'b0;
    if (en) begin
      case (op)
        3'd0: m_pc = s;
        3'd1: m_pc = z ? tgt : s;
        3'd2: m_pc = !z ? tgt : s;
        3'd3: m_pc = tgt;
        3'd4: begin
          if (m_ras.size() < D) m_ras.push_back(s);
          else set_o = 1'b1;
          m_pc = tgt;
        end
        3'd5: begin
          if (m_ras.size() > 0) m_pc = m_ras.pop_back();
          else set_u = 1'b1;
        end
        default: ;
      endcase
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (set_o) m_ovf = 1'b1;
    if (set_u) m_unf = 1'b1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.pc    = bus.pc;
    o.cnt   = bus.ras_count;
    o.full  = bus.ras_full;
    o.empty = bus.ras_empty;
    o.ovf   = bus.ras_ovf;
    o.unf   = bus.ras_unf;
    return o;
  endfunction

  // one clocked operation: expected pushed at drive time, DUT sampled after the edge
  task automatic drive(input logic en, input logic [2:0] op, input logic z,
                       input logic [W-1:0] tgt, input logic clr);
    @(negedge clock);
    bus.en      = en;
    bus.op      = op;
    bus.is_zero = z;
    bus.target  = tgt;
    bus.clr_err = clr;
    model_step(en, op, z, tgt, clr);
    exp_q.push_back(model_obs());
    @(posedge clock);
    #1;
    act_q.push_back(sample());
    bus.en      = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic test_reset();
    obs_t e, a;
    bus.en = 1'b0; bus.op = 3'd0; bus.is_zero = 1'b0;
    bus.target = '0; bus.clr_err = 1'b0;
    model_reset();
    #1;
    total++;
    if (bus.pc !== 16'h0 || bus.ras_count !== 3'd0 || bus.ras_ovf !== 1'b0 ||
        bus.ras_unf !== 1'b0 || bus.ras_empty !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: got pc=%h cnt=%0d ovf=%b unf=%b, expected pc=0000 cnt=0 flags 0",
               bus.pc, bus.ras_count, bus.ras_ovf, bus.ras_unf);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(1'b1, 3'd0, 1'b0, '0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL reset_seq: got pc=%h cnt=%0d flags=%b%b%b%b, expected pc=%h cnt=%0d flags=%b%b%b%b",
                 a.pc, a.cnt, a.full, a.empty, a.ovf, a.unf, e.pc, e.cnt, e.full, e.empty, e.ovf, e.unf);
      end
    end
    total++;
    if (bus.pc !== 16'h3) begin
      bad++; $display("FAIL seq_to_3: got pc=%h, expected 0003", bus.pc);
    end
    // asynchronous reset well away from any clock edge
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    total++;
    if (bus.pc !== 16'h0) begin
      bad++; $display("FAIL async_reset: got pc=%h, expected 0000 before any edge", bus.pc);
    end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_branch();
    obs_t e, a;
    drive(1'b1, 3'd3, 1'b0, 16'h5, 1'b0);
    drive(1'b1, 3'd1, 1'b1, 16'h40, 1'b0);
    total++;
    if (bus.pc !== 16'h40) begin
      bad++; $display("FAIL beq_taken: got pc=%h, expected 0040", bus.pc);
    end
    drive(1'b1, 3'd2, 1'b1, 16'h10, 1'b0);
    drive(1'b0, 3'd3, 1'b0, 16'h99, 1'b0);
    total++;
    if (bus.pc !== 16'h41) begin
      bad++; $display("FAIL en_low_hold: got pc=%h, expected 0041", bus.pc);
    end
    drive(1'b1, 3'd1, 1'b0, 16'h70, 1'b0);  // BEQ not taken
    drive(1'b1, 3'd2, 1'b0, 16'h70, 1'b0);  // BNE taken
    drive(1'b1, 3'd6, 1'b0, 16'h11, 1'b0);  // HOLD
    drive(1'b1, 3'd7, 1'b0, 16'h22, 1'b0);  // reserved
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL branch: got pc=%h cnt=%0d flags=%b%b%b%b, expected pc=%h cnt=%0d flags=%b%b%b%b",
                 a.pc, a.cnt, a.full, a.empty, a.ovf, a.unf, e.pc, e.cnt, e.full, e.empty, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_nested_call();
    obs_t e, a;
    drive(1'b1, 3'd3, 1'b0, 16'h20, 1'b0);
    drive(1'b1, 3'd4, 1'b0, 16'h100, 1'b0);
    drive(1'b1, 3'd4, 1'b0, 16'h200, 1'b0);
    drive(1'b1, 3'd0, 1'b0, 16'h0, 1'b0);   // non-stack op between
    drive(1'b1, 3'd5, 1'b0, 16'h0, 1'b0);
    total++;
    if (bus.pc !== 16'h101 || bus.ras_count !== 3'd1) begin
      bad++; $display("FAIL ret_inner: got pc=%h cnt=%0d, expected 0101 1", bus.pc, bus.ras_count);
    end
    drive(1'b1, 3'd5, 1'b0, 16'h0, 1'b0);
    total++;
    if (bus.pc !== 16'h21 || bus.ras_empty !== 1'b1) begin
      bad++; $display("FAIL ret_outer: got pc=%h empty=%b, expected 0021 1", bus.pc, bus.ras_empty);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL nested: got pc=%h cnt=%0d flags=%b%b%b%b, expected pc=%h cnt=%0d flags=%b%b%b%b",
                 a.pc, a.cnt, a.full, a.empty, a.ovf, a.unf, e.pc, e.cnt, e.full, e.empty, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_overflow();
    obs_t e, a;
    drive(1'b1, 3'd3, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) drive(1'b1, 3'd4, 1'b0, 16'(16'h10 + i), 1'b0);
    total++;
    if (bus.pc !== 16'h14 || bus.ras_count !== 3'd4 || bus.ras_full !== 1'b1 ||
        bus.ras_ovf !== 1'b1) begin
      bad++;
      $display("FAIL overflow: got pc=%h cnt=%0d full=%b ovf=%b, expected 0014 4 1 1",
               bus.pc, bus.ras_count, bus.ras_full, bus.ras_ovf);
    end
    for (int i = 0; i < 4; i++) drive(1'b1, 3'd5, 1'b0, 16'h0, 1'b0);
    total++;
    if (bus.pc !== 16'h1 || bus.ras_ovf !== 1'b1) begin
      bad++; $display("FAIL ovf_unwind: got pc=%h ovf=%b, expected 0001 1", bus.pc, bus.ras_ovf);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL ovf_seq: got pc=%h cnt=%0d flags=%b%b%b%b, expected pc=%h cnt=%0d flags=%b%b%b%b",
                 a.pc, a.cnt, a.full, a.empty, a.ovf, a.unf, e.pc, e.cnt, e.full, e.empty, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_underflow();
    obs_t e, a;
    drive(1'b0, 3'd6, 1'b0, 16'h0, 1'b1);   // clr_err with en low
    drive(1'b1, 3'd3, 1'b0, 16'h30, 1'b0);
    drive(1'b1, 3'd5, 1'b0, 16'h0, 1'b0);
    total++;
    if (bus.pc !== 16'h30 || bus.ras_unf !== 1'b1) begin
      bad++; $display("FAIL unf_set: got pc=%h unf=%b, expected 0030 1", bus.pc, bus.ras_unf);
    end
    drive(1'b1, 3'd5, 1'b0, 16'h0, 1'b1);
    total++;
    if (bus.ras_unf !== 1'b1) begin
      bad++; $display("FAIL unf_set_wins: got unf=%b, expected 1", bus.ras_unf);
    end
    drive(1'b1, 3'd0, 1'b0, 16'h0, 1'b1);
    total++;
    if (bus.ras_unf !== 1'b0 || bus.pc !== 16'h31) begin
      bad++; $display("FAIL unf_clear: got unf=%b pc=%h, expected 0 0031", bus.ras_unf, bus.pc);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL unf_seq: got pc=%h cnt=%0d flags=%b%b%b%b, expected pc=%h cnt=%0d flags=%b%b%b%b",
                 a.pc, a.cnt, a.full, a.empty, a.ovf, a.unf, e.pc, e.cnt, e.full, e.empty, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e, a;
    drive(1'b1, 3'd3, 1'b0, 16'hFFFF, 1'b0);
    drive(1'b1, 3'd0, 1'b0, 16'h0, 1'b0);
    total++;
    if (bus.pc !== 16'h0000) begin
      bad++; $display("FAIL wrap_next: got pc=%h, expected 0000", bus.pc);
    end
    drive(1'b1, 3'd3, 1'b0, 16'hFFFF, 1'b0);
    drive(1'b1, 3'd4, 1'b0, 16'h8, 1'b0);
    drive(1'b1, 3'd5, 1'b0, 16'h0, 1'b0);   // immediately after the push
    total++;
    if (bus.pc !== 16'h0000 || bus.ras_count !== 3'd0) begin
      bad++; $display("FAIL wrap_ret: got pc=%h cnt=%0d, expected 0000 0", bus.pc, bus.ras_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL wrap_seq: got pc=%h cnt=%0d flags=%b%b%b%b, expected pc=%h cnt=%0d flags=%b%b%b%b",
                 a.pc, a.cnt, a.full, a.empty, a.ovf, a.unf, e.pc, e.cnt, e.full, e.empty, e.ovf, e.unf);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, a;
    drive(1'b1, 3'd3, 1'b0, 16'h500, 1'b0);
    for (int i = 0; i < 12; i++)
      drive(1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            16'($urandom_range(0, 16'hFFFF)), 1'($urandom_range(0, 3) == 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); total++;
      if (a !== e) begin
        bad++;
        $display("FAIL b2b: got pc=%h cnt=%0d flags=%b%b%b%b, expected pc=%h cnt=%0d flags=%b%b%b%b",
                 a.pc, a.cnt, a.full, a.empty, a.ovf, a.unf, e.pc, e.cnt, e.full, e.empty, e.ovf, e.unf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_nested_call();
    test_overflow();
    test_underflow();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
